timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped programmable countdown timer on the CPU's peripheral bus, upstream of the coprocessor-0 exception unit. Software programs a preset and a control word with sw; the block counts down and raises an interrupt request. That request drives one bit of the 6-bit hardware-interrupt vector (HWInt[2] in the standard build) sampled by CP0 every cycle. Two modes are supported: one-shot with a sticky interrupt, and auto-reload with a one-cycle interrupt pulse.

## Interface
Parameters:
- WIDTH, 32, counter/preset/data width
- RESET_MODE, 2'b00, mode field value after reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- addr  input  [3:2]  word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = PRESCALE (see Configuration)
- we  input  1  bus write enable, one write per cycle
- wdata  input  WIDTH  write data
- rdata  output  WIDTH  combinational read of the addressed register
- irq  output  1  interrupt request to CP0 HWInt

## Operation
- CTRL layout:
  - [0] EN: count enable
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, others behave as 00
  - [3] IM: interrupt mask, 1 = irq permitted
  - [31:4] read as 0, writes ignored
- PRESET: read/write.
- COUNT: read-only; writes ignored.
- Reset values: CTRL = {28'b0, 1'b0, RESET_MODE, 1'b0}, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0, rdata follows addr, irq = 0.
- State machine, one transition per clock:
  - IDLE: COUNT holds. EN = 1 → LOAD.
  - LOAD: COUNT ← PRESET → CNT.
  - CNT: EN = 0 → IDLE with COUNT frozen. Else if COUNT > 1: COUNT ← COUNT − 1. Else: COUNT ← 0 → INT.
  - INT:
    - MODE 00: irq_flag ← 1, EN ← 0 → IDLE.
    - MODE 01: irq_flag ← 1 for this cycle only → LOAD.
- irq = IM & irq_flag.
  - Mode 00: irq_flag is sticky. It clears on any CTRL write.
  - Mode 01: irq_flag is high only during the INT cycle.
- PRESET = 0: LOAD → CNT(count 0) → INT, so the terminal event occurs 2 cycles after LOAD.
- A bus write and a counter update in the same cycle: the write takes effect and the internal update to the same field is dropped.
  - A CTRL write during INT overrides the EN clear.
  - A PRESET write does not touch COUNT until the next LOAD.
- Writing EN = 0 mid-count freezes COUNT. Writing EN = 1 again reloads from PRESET; the count does not resume.

## Timing
- Writes commit on the rising edge after we is sampled high. Reads are combinational, same cycle.
- From a CTRL write with EN = 1 (edge 0): LOAD at edge 1, COUNT = PRESET visible after edge 2, first decrement at edge 3.
- With PRESET = N ≥ 1: INT is entered N+1 edges after LOAD. irq rises the edge after INT is entered, i.e. N+3 edges after the enabling write.
- Auto-reload period: N+2 cycles per irq pulse.
- Async reset asserted mid-count: COUNT, CTRL and irq go to reset values immediately, with no clock needed. Release is synchronous to the next edge.

## Configuration
- TIMER_PRESCALE_EN:
  - Defined: adds the PRESCALE register (word 3, bits [15:0], reset 0). In CNT, COUNT decrements only on prescaler ticks, one tick every PRESCALE+1 clocks. The prescaler counter restarts in LOAD.
  - Undefined: every CNT cycle ticks; word 3 reads 0 and writes are ignored.
- All other behaviour is identical in both builds.

## Structure
- Shared package timer_pkg holds:
  - state encoding: IDLE / LOAD / CNT / INT
  - MODE encodings
  - register word indices
  - CTRL bit positions
- Sub-module timer_prescaler (tick generator: load/clear input, tick output) is instantiated only under TIMER_PRESCALE_EN.

## Test plan
- PRESET = 5, CTRL = 0x9 (EN, mode 00, IM) → irq rises 8 edges after the write; COUNT = 0; EN reads 0; irq stays high until CTRL is written with 0x8, then falls the next edge.
- PRESET = 3, CTRL = 0xB (auto-reload, IM) → single-cycle irq pulses every 5 cycles. COUNT sequence after each reload: 3, 2, 1, 0.
- PRESET = 10 counting, write CTRL = 0x8 at COUNT = 6 → COUNT frozen at 6. Rewrite 0x9 → COUNT reloads to 10.
- IM = 0, mode 00, PRESET = 2 → state reaches INT and irq_flag sets, but irq stays 0. A later CTRL write of 0x8 clears the flag, so irq stays 0.
- Assert reset low for a half-cycle mid-count with PRESET = 100 → COUNT = 0, CTRL = 0 and irq = 0 immediately, with no clock edge.
- TIMER_PRESCALE_EN defined, PRESCALE = 3, PRESET = 2 → decrements every 4 clocks; irq after LOAD + 1 + 2×4 + 1 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared encodings for the timer_counter block (FSM states,
//               MODE values, register word indices, CTRL bit positions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] c_MODE_ONESHOT = 2'b00;
    localparam logic [1:0] c_MODE_RELOAD  = 2'b01;

    localparam logic [1:0] c_ADDR_CTRL     = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET   = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT    = 2'd2;
    localparam logic [1:0] c_ADDR_PRESCALE = 2'd3;

    localparam int c_BIT_EN      = 0;
    localparam int c_BIT_MODE_LO = 1;
    localparam int c_BIT_MODE_HI = 2;
    localparam int c_BIT_IM      = 3;

    // Only 01 reloads; the two reserved encodings fall back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == c_MODE_RELOAD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_counter_if.sv
// ============================================================================
// Module      : timer_counter_if
// Description : Peripheral-bus port bundle of the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_counter_if #(
    parameter int WIDTH = 32
);
    logic [3:2]       addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module      : timer_prescaler
// Description : Tick generator, one tick every i_div+1 enabled clocks;
//               i_clr restarts the phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_clr,
    input  wire logic        i_en,
    input  wire logic [15:0] i_div,
    output logic             o_tick
);
    logic [15:0] r_cnt;

    // >= keeps the divider from stalling when i_div shrinks below r_cnt.
    assign o_tick = i_en && (r_cnt >= i_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? 16'd0 : r_cnt + 16'd1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// Module      : timer_counter
// Description : Memory-mapped countdown timer with one-shot / auto-reload
//               modes and an interrupt request for CP0. Optional PRESCALE
//               register enabled by macro TIMER_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_counter
    import timer_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter logic [1:0] RESET_MODE = 2'b00
) (
    input  wire logic      clk,
    input  wire logic      reset,
    timer_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic             r_irq_flag;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic             w_int_hit;
    logic             w_tick;
    logic             w_wr_ctrl;
    logic             w_wr_preset;

    assign w_wr_ctrl   = bus.we && (bus.addr == c_ADDR_CTRL);
    assign w_wr_preset = bus.we && (bus.addr == c_ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] r_prescale;
    logic        w_wr_prescale;

    assign w_wr_prescale = bus.we && (bus.addr == c_ADDR_PRESCALE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prescale <= '0;
        end else if (w_wr_prescale) begin
            r_prescale <= bus.wdata[15:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_load),
        .i_en   (r_state == S_CNT),
        .i_div  (r_prescale),
        .o_tick (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_zero      = 1'b0;
        w_int_hit   = 1'b0;
        case (r_state)
            S_IDLE: if (r_en) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (r_count > c_ONE) begin
                        w_dec = 1'b1;
                    end else begin
                        w_zero      = 1'b1;
                        w_state_nxt = S_INT;
                    end
                end
            end
            S_INT: begin
                w_int_hit   = 1'b1;
                w_state_nxt = is_reload(r_mode) ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A CTRL write wins over the one-shot EN clear and over the flag update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en       <= 1'b0;
            r_mode     <= RESET_MODE;
            r_im       <= 1'b0;
            r_irq_flag <= 1'b0;
            r_preset   <= '0;
            r_count    <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= bus.wdata[c_BIT_EN];
                r_mode <= bus.wdata[c_BIT_MODE_HI:c_BIT_MODE_LO];
                r_im   <= bus.wdata[c_BIT_IM];
            end else if (w_int_hit && !is_reload(r_mode)) begin
                r_en <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_irq_flag <= 1'b0;
            end else if (w_int_hit) begin
                r_irq_flag <= 1'b1;
            end else if (is_reload(r_mode)) begin
                r_irq_flag <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= bus.wdata;
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - c_ONE;
            end else if (w_zero) begin
                r_count <= '0;
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            c_ADDR_CTRL:   bus.rdata = {{(WIDTH-4){1'b0}}, r_im, r_mode, r_en};
            c_ADDR_PRESET: bus.rdata = r_preset;
            c_ADDR_COUNT:  bus.rdata = r_count;
`ifdef TIMER_PRESCALE_EN
            c_ADDR_PRESCALE: bus.rdata = {{(WIDTH-16){1'b0}}, r_prescale};
`endif
            default:       bus.rdata = '0;
        endcase
    end

    assign bus.irq = r_im & r_irq_flag;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ============================================================================
// Module      : tb_timer_counter
// Description : Self-checking bench for timer_counter (scoreboard queue of
//               expected values, one task per scenario).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_counter;
    import timer_pkg::*;

    logic        clk;
    logic        reset;
    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] v;

    timer_counter_if #(.WIDTH(32)) bus ();

    timer_counter #(.WIDTH(32), .RESET_MODE(2'b00)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write; returns 1 time unit after the committing edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] val);
        bus.addr = a;
        #1;
        val = bus.rdata;
    endtask

    task automatic test_reset;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        step(2);
        rd(c_ADDR_CTRL, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", v, exp); end
        rd(c_ADDR_PRESET, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL reset_preset: got %h want %h", v, exp); end
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL reset_count: got %h want %h", v, exp); end
        rd(c_ADDR_PRESCALE, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL reset_prescale: got %h want %h", v, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL reset_irq: got %b want %b", bus.irq, exp[0]); end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_oneshot;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(32'h8); exp_q.push_back(1); exp_q.push_back(0);
        bus_write(c_ADDR_PRESET, 32'd5);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(7);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL oneshot_irq_early: got %b want %b", bus.irq, exp[0]); end
        step(1);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL oneshot_irq_rise: got %b want %b", bus.irq, exp[0]); end
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL oneshot_count: got %h want %h", v, exp); end
        rd(c_ADDR_CTRL, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL oneshot_ctrl: got %h want %h", v, exp); end
        step(3);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL oneshot_sticky: got %b want %b", bus.irq, exp[0]); end
        bus_write(c_ADDR_CTRL, 32'h8);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL oneshot_clear: got %b want %b", bus.irq, exp[0]); end
    endtask

    task automatic test_autoreload;
        logic [31:0] c_exp;
        for (int e = 1; e <= 17; e++) begin
            case ((e - 2) % 5)
                0: c_exp = 3;
                1: c_exp = 2;
                2: c_exp = 1;
                default: c_exp = 0;
            endcase
            exp_q.push_back((e < 2) ? 32'd0 : c_exp);
            exp_q.push_back((e >= 6 && ((e - 6) % 5) == 0) ? 32'd1 : 32'd0);
        end
        bus_write(c_ADDR_PRESET, 32'd3);
        bus_write(c_ADDR_CTRL, 32'hB);
        for (int e = 1; e <= 17; e++) begin
            step(1);
            rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
            if (v !== exp) begin n_err++; $display("FAIL reload_count e%0d: got %0d want %0d", e, v, exp); end
            exp = exp_q.pop_front(); n_vec++;
            if (bus.irq !== exp[0]) begin n_err++; $display("FAIL reload_irq e%0d: got %b want %b", e, bus.irq, exp[0]); end
        end
        bus_write(c_ADDR_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(2); exp_q.push_back(1);
        bus_write(c_ADDR_PRESET, 32'd3);
        bus_write(c_ADDR_CTRL, 32'hB);
        step(2);
        bus_write(c_ADDR_PRESET, 32'd1);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL preset_wr_count: got %0d want %0d", v, exp); end
        step(4);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL preset_wr_reload: got %0d want %0d", v, exp); end
        bus_write(c_ADDR_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_freeze;
        exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(6); exp_q.push_back(10);
        bus_write(c_ADDR_PRESET, 32'd10);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(5);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL freeze_pre: got %0d want %0d", v, exp); end
        bus_write(c_ADDR_CTRL, 32'h8);
        step(3);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL freeze_hold: got %0d want %0d", v, exp); end
        bus_write(c_ADDR_CTRL, 32'h9);
        step(1);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL freeze_load_state: got %0d want %0d", v, exp); end
        step(1);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL freeze_reload: got %0d want %0d", v, exp); end
        bus_write(c_ADDR_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_preset_zero;
        exp_q.push_back(0); exp_q.push_back(1);
        bus_write(c_ADDR_PRESET, 32'd0);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(3);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL zero_irq_early: got %b want %b", bus.irq, exp[0]); end
        step(1);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL zero_irq_rise: got %b want %b", bus.irq, exp[0]); end
        bus_write(c_ADDR_CTRL, 32'h8);
    endtask

    task automatic test_ctrl_during_int;
        exp_q.push_back(32'h9); exp_q.push_back(1);
        bus_write(c_ADDR_PRESET, 32'd1);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(3);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(1);
        rd(c_ADDR_CTRL, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL int_wr_ctrl: got %h want %h", v, exp); end
        step(3);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL int_wr_irq: got %b want %b", bus.irq, exp[0]); end
        bus_write(c_ADDR_CTRL, 32'h8);
    endtask

    task automatic test_masked;
        for (int e = 1; e <= 8; e++) exp_q.push_back(0);
        exp_q.push_back(32'h0); exp_q.push_back(0); exp_q.push_back(0);
        bus_write(c_ADDR_PRESET, 32'd2);
        bus_write(c_ADDR_CTRL, 32'h1);
        for (int e = 1; e <= 8; e++) begin
            step(1);
            exp = exp_q.pop_front(); n_vec++;
            if (bus.irq !== exp[0]) begin n_err++; $display("FAIL masked_irq e%0d: got %b want %b", e, bus.irq, exp[0]); end
        end
        rd(c_ADDR_CTRL, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL masked_ctrl: got %h want %h", v, exp); end
        bus_write(c_ADDR_CTRL, 32'h8);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL masked_clr_irq: got %b want %b", bus.irq, exp[0]); end
        step(2);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL masked_clr_irq_late: got %b want %b", bus.irq, exp[0]); end
        bus_write(c_ADDR_CTRL, 32'h0);
    endtask

    task automatic test_async_reset;
        exp_q.push_back(92); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(0); exp_q.push_back(0);
        bus_write(c_ADDR_PRESET, 32'd100);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(10);
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL arst_pre_count: got %0d want %0d", v, exp); end
        #2;
        reset = 1'b0;
        #1;
        rd(c_ADDR_COUNT, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL arst_count: got %0d want %0d", v, exp); end
        rd(c_ADDR_CTRL, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL arst_ctrl: got %h want %h", v, exp); end
        rd(c_ADDR_PRESET, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL arst_preset: got %0d want %0d", v, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL arst_irq: got %b want %b", bus.irq, exp[0]); end
        reset = 1'b1;
        step(1);
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale;
        exp_q.push_back(32'd3); exp_q.push_back(0); exp_q.push_back(1);
        bus_write(c_ADDR_PRESCALE, 32'd3);
        rd(c_ADDR_PRESCALE, v); exp = exp_q.pop_front(); n_vec++;
        if (v !== exp) begin n_err++; $display("FAIL prescale_reg: got %0d want %0d", v, exp); end
        bus_write(c_ADDR_PRESET, 32'd2);
        bus_write(c_ADDR_CTRL, 32'h9);
        step(10);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL prescale_irq_early: got %b want %b", bus.irq, exp[0]); end
        step(1);
        exp = exp_q.pop_front(); n_vec++;
        if (bus.irq !== exp[0]) begin n_err++; $display("FAIL prescale_irq_rise: got %b want %b", bus.irq, exp[0]); end
        bus_write(c_ADDR_CTRL, 32'h0);
        bus_write(c_ADDR_PRESCALE, 32'd0);
    endtask
`endif

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        bus.addr  = c_ADDR_CTRL;
        bus.we    = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_back_to_back();
        test_freeze();
        test_preset_zero();
        test_ctrl_during_int();
        test_masked();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
